// File: rtl/fb_pkg.sv
// fb_pkg: shared geometry and state encoding for the waterfall frame buffer.
// Imported by fb_row_addr and fb_scroll_scheduler.
package fb_pkg;

    localparam int FB_WIDTH        = 320;
    localparam int FB_HEIGHT       = 240;
    localparam int FB_ADDR_W       = 17;
    localparam int FB_DATA_W       = 8;
    localparam int FB_SCROLL_DIV_W = 2;

    typedef enum logic [1:0] {
        S_CLEAR      = 2'd0,
        S_VIDEO      = 2'd1,
        S_WRITE      = 2'd2,
        S_WAIT_VIDEO = 2'd3
    } fb_state_t;

endpackage

// File: rtl/fb_row_addr.sv
// fb_row_addr: combinational linear address row*WIDTH + col.
// Ports: row (row index), col (column index), addr (RAM address).
module fb_row_addr
    import fb_pkg::*;
#(
    parameter int WIDTH  = FB_WIDTH,
    parameter int ADDR_W = FB_ADDR_W,
    parameter int ROW_W  = 8,
    parameter int COL_W  = 9
) (
    input  logic [ROW_W-1:0]  row,
    input  logic [COL_W-1:0]  col,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] row_ext;
    logic [ADDR_W-1:0] col_ext;
    logic [ADDR_W-1:0] row_base;

    assign row_ext = ADDR_W'(row);
    assign col_ext = ADDR_W'(col);

    generate
        if (WIDTH == 320) begin : g_shift
            // 320 = 5 * 64: one add and two shifts instead of a multiplier.
            assign row_base = ((row_ext << 2) + row_ext) << 6;
        end else begin : g_mul
            assign row_base = row_ext * ADDR_W'(WIDTH);
        end
    endgenerate

    assign addr = row_base + col_ext;

endmodule

// File: rtl/fb_scroll_scheduler.sv
// fb_scroll_scheduler: time-shares the single-port frame buffer between the LCD
// scan-out reader (active video, circular row offset) and a line producer that
// writes one new row per scroll during lower blanking; clears the RAM after reset.
// Ports: clk/reset (async, active-high); x, y, lower_blank from video timing;
// line_req, wr_valid, wr_data, wr_ready producer handshake; ram_addr, ram_wdata,
// ram_we to the RAM; y_offset, clear_done, line_overrun status.
// Build option: define SCROLL_PAUSE_EN to add the scroll_pause input.
module fb_scroll_scheduler
    import fb_pkg::*;
#(
    parameter int WIDTH        = FB_WIDTH,
    parameter int HEIGHT       = FB_HEIGHT,
    parameter int ADDR_W       = FB_ADDR_W,
    parameter int DATA_W       = FB_DATA_W,
    parameter int SCROLL_DIV_W = FB_SCROLL_DIV_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [8:0]        x,
    input  logic [7:0]        y,
    input  logic              lower_blank,
    output logic              line_req,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic [7:0]        y_offset,
    output logic              clear_done,
    output logic              line_overrun
`ifdef SCROLL_PAUSE_EN
    ,
    input  logic              scroll_pause
`endif
);

    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(WIDTH * HEIGHT - 1);
    localparam logic [8:0]        COL_LAST = 9'(WIDTH - 1);
    localparam logic [7:0]        ROW_LAST = 8'(HEIGHT - 1);
    localparam logic [8:0]        HEIGHT_9 = 9'(HEIGHT);

    fb_state_t         state, state_d;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_d;
    logic [8:0]        col, col_d;
    logic [SCROLL_DIV_W-1:0] scroll_cnt, scroll_d;
    logic              lb_q;
    logic [7:0]        ymod_r, ymod_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              req_q, req_d;
    logic [7:0]        yoff_q, yoff_d;
    logic              done_q, done_d;
    logic              ovr_q, ovr_d;

    logic              pause;
    logic              lb_rise;
    logic [8:0]        sum9;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;

`ifdef SCROLL_PAUSE_EN
    assign pause = scroll_pause;
`else
    assign pause = 1'b0;
`endif

    assign lb_rise = lower_blank & ~lb_q;

    // Circular row: y + offset folded back into 0..HEIGHT-1.
    assign sum9   = {1'b0, y} + {1'b0, yoff_q};
    assign ymod_d = (sum9 >= HEIGHT_9) ? 8'(sum9 - HEIGHT_9) : sum9[7:0];

    fb_row_addr #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_rd_addr (
        .row  (ymod_r),
        .col  (x),
        .addr (rd_addr)
    );

    fb_row_addr #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_wr_addr (
        .row  (yoff_q),
        .col  (col),
        .addr (wr_addr)
    );

    always_comb begin
        state_d   = state;
        clr_cnt_d = clr_cnt;
        col_d     = col;
        scroll_d  = scroll_cnt;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = 1'b0;
        req_d     = 1'b0;
        yoff_d    = yoff_q;
        done_d    = done_q;
        ovr_d     = ovr_q;
        unique case (state)
            S_CLEAR: begin
                if (we_q && addr_q == CLR_LAST) begin
                    done_d  = 1'b1;
                    state_d = S_VIDEO;
                end else begin
                    we_d      = 1'b1;
                    wdata_d   = '0;
                    addr_d    = clr_cnt;
                    clr_cnt_d = clr_cnt + 1'b1;
                end
            end
            S_VIDEO: begin
                addr_d = rd_addr;
                if (lb_rise && pause) begin
                    state_d = S_WAIT_VIDEO;
                end else if (lb_rise) begin
                    scroll_d = scroll_cnt + 1'b1;
                    if (&scroll_cnt) begin
                        req_d   = 1'b1;
                        col_d   = '0;
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_WAIT_VIDEO;
                    end
                end
            end
            S_WRITE: begin
                if (!lower_blank) begin
                    // Blanking ended mid-line: leave the partial row.
                    ovr_d   = 1'b1;
                    state_d = S_VIDEO;
                end else if (wr_valid) begin
                    we_d    = 1'b1;
                    addr_d  = wr_addr;
                    wdata_d = wr_data;
                    col_d   = col + 1'b1;
                    if (col == COL_LAST) begin
                        yoff_d  = (yoff_q == ROW_LAST) ? 8'd0
                                                       : yoff_q + 8'd1;
                        state_d = S_WAIT_VIDEO;
                    end
                end
            end
            S_WAIT_VIDEO: begin
                addr_d = rd_addr;
                if (!lower_blank) begin
                    state_d = S_VIDEO;
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_CLEAR;
            clr_cnt    <= '0;
            col        <= '0;
            scroll_cnt <= '0;
            lb_q       <= 1'b0;
            ymod_r     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            req_q      <= 1'b0;
            yoff_q     <= '0;
            done_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state      <= state_d;
            clr_cnt    <= clr_cnt_d;
            col        <= col_d;
            scroll_cnt <= scroll_d;
            lb_q       <= lower_blank;
            ymod_r     <= ymod_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            req_q      <= req_d;
            yoff_q     <= yoff_d;
            done_q     <= done_d;
            ovr_q      <= ovr_d;
        end
    end

    // A write registered on the last blank cycle must not land in active video.
    assign ram_we       = we_q & (~done_q | lower_blank);
    assign wr_ready     = (state == S_WRITE) & lower_blank;
    assign ram_addr     = addr_q;
    assign ram_wdata    = wdata_q;
    assign line_req     = req_q;
    assign y_offset     = yoff_q;
    assign clear_done   = done_q;
    assign line_overrun = ovr_q;

endmodule

// File: tb/tb_fb_scroll_scheduler.sv
// tb_fb_scroll_scheduler: directed + randomized bench for fb_scroll_scheduler.
// Uses a reduced HEIGHT so row wrap and repeated clears fit a short run.
module tb_fb_scroll_scheduler;

    localparam int W          = 320;
    localparam int H          = 12;
    localparam int AW         = 17;
    localparam int N          = W * H;
    localparam int LINE_BLANK = 900;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [8:0]    x = '0;
    logic [7:0]    y = '0;
    logic          lower_blank = 1'b0;
    logic          line_req;
    logic          wr_valid = 1'b0;
    logic [7:0]    wr_data;
    logic          wr_ready;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_wdata;
    logic          ram_we;
    logic [7:0]    y_offset;
    logic          clear_done;
    logic          line_overrun;
    logic          pause_on = 1'b0;

    int checks   = 0;
    int failures = 0;

    fb_scroll_scheduler #(
        .WIDTH  (W),
        .HEIGHT (H),
        .ADDR_W (AW),
        .DATA_W (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .x            (x),
        .y            (y),
        .lower_blank  (lower_blank),
        .line_req     (line_req),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_we       (ram_we),
        .y_offset     (y_offset),
        .clear_done   (clear_done),
        .line_overrun (line_overrun)
`ifdef SCROLL_PAUSE_EN
        ,
        .scroll_pause (pause_on)
`endif
    );

    always #5 clk = ~clk;

    // Producer: data = column index of the current line.
    int pcol       = 0;
    int prod_mode  = 0;
    int prod_limit = W;

    assign wr_data = 8'(pcol);

    always @(posedge clk) begin
        if (reset || !lower_blank) pcol <= 0;
        else if (wr_valid && wr_ready) pcol <= pcol + 1;
    end

    always @(posedge clk) begin
        #2;
        wr_valid = (prod_mode != 0) && (pcol < prod_limit) &&
                   (prod_mode == 1 || $urandom_range(0, 3) != 0);
    end

    // Monitor
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    wr_t wq[$];
    int  clr_idx = 0;
    int  clr_bad = 0;
    int  req_cnt = 0;
    int  lb_viol = 0;

    always @(negedge clk) begin
        if (reset) begin
            clr_idx = 0;
            clr_bad = 0;
        end else begin
            if (ram_we && !clear_done) begin
                if (ram_addr !== AW'(clr_idx) || ram_wdata !== 8'd0) clr_bad++;
                clr_idx++;
            end
            if (ram_we && clear_done) wq.push_back({ram_addr, ram_wdata});
            if (ram_we && clear_done && !lower_blank) lb_viol++;
            if (line_req) req_cnt++;
        end
    end

    // Reference model state
    int exp_yoff = 0;
    int exp_ovr  = 0;
    int fcnt     = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic read_check(input string tag, input int xv, input int yv);
        x = 9'(xv);
        y = 8'(yv);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(tag, 32'(ram_addr), 32'(xv + ((yv + exp_yoff) % H) * W));
        cyc();
    endtask

    task automatic wait_clear();
        int n;
        n = 0;
        while (!clear_done && n < N + 50) begin
            cyc();
            n++;
        end
        @(negedge clk);
        chk("clear_done", 32'(clear_done), 32'd1);
        chk("clear_write_cycles", clr_idx, N);
        chk("clear_seq_errors", clr_bad, 0);
        chk("ram_we_after_clear", 32'(ram_we), 32'd0);
        cyc();
    endtask

    task automatic frame(input int exp_pix);
        bit do_line;
        int rq0;
        int bad;
        int row;
        lower_blank = 1'b0;
        cyc();
        cyc();
        read_check("scan_read", $urandom_range(0, W - 1), $urandom_range(0, H - 1));
        wq.delete();
        rq0 = req_cnt;
        do_line = !pause_on && (fcnt % 4 == 3);
        if (!pause_on) fcnt++;
        row = exp_yoff;
        lower_blank = 1'b1;
        repeat (do_line ? LINE_BLANK : 3) cyc();
        lower_blank = 1'b0;
        cyc();
        cyc();
        @(negedge clk);
        chk("line_req_count", req_cnt - rq0, do_line ? 1 : 0);
        chk("write_count", wq.size(), do_line ? exp_pix : 0);
        bad = 0;
        foreach (wq[i]) begin
            if (wq[i].addr !== AW'(row * W + i) || wq[i].data !== 8'(i)) bad++;
        end
        chk("write_content", bad, 0);
        if (do_line && exp_pix == W) exp_yoff = (exp_yoff + 1) % H;
        if (do_line && exp_pix < W) exp_ovr = 1;
        chk("y_offset", 32'(y_offset), exp_yoff);
        chk("line_overrun", 32'(line_overrun), exp_ovr);
        cyc();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_flags", 32'({line_req, wr_ready, clear_done, line_overrun}), 32'd0);
        chk("rst_y_offset", 32'(y_offset), 32'd0);
        cyc();
        reset = 1'b0;

        // Post-reset clear
        wait_clear();

        // First scroll with an always-valid producer
        prod_mode = 1;
        repeat (4) frame(W);

        // Randomized producer throttling up to the last row
        prod_mode = 2;
        while (exp_yoff != H - 1) frame(W);

        // Row wrap
        prod_mode = 1;
        do frame(W); while (exp_yoff != 0);
        read_check("wrap_read", 0, 1);
        x = 9'd0;
        y = 8'd1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("wrap_read_addr320", 32'(ram_addr), 32'd320);
        cyc();

        // Producer stall: line aborted at end of blanking
        prod_limit = 100;
        repeat (4) frame(100);
        read_check("read_after_overrun", $urandom_range(0, W - 1), $urandom_range(0, H - 1));
        prod_limit = W;
        repeat (4) frame(W);

        // Reset in the middle of a line write
        while (fcnt % 4 != 3) frame(W);
        lower_blank = 1'b0;
        cyc();
        cyc();
        wq.delete();
        lower_blank = 1'b1;
        n = 0;
        while (wq.size() < 150 && n < 1000) begin
            cyc();
            n++;
        end
        chk("midline_reached", 32'(wq.size() >= 150), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("async_rst_ram_we", 32'(ram_we), 32'd0);
        chk("async_rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("async_rst_wdata", 32'(ram_wdata), 32'd0);
        chk("async_rst_flags", 32'({line_req, wr_ready, clear_done, line_overrun}), 32'd0);
        chk("async_rst_y_offset", 32'(y_offset), 32'd0);
        lower_blank = 1'b0;
        exp_yoff = 0;
        exp_ovr = 0;
        fcnt = 0;
        cyc();
        cyc();
        reset = 1'b0;
        wait_clear();

`ifdef SCROLL_PAUSE_EN
        pause_on = 1'b1;
        repeat (8) frame(W);
        pause_on = 1'b0;
`endif
        repeat (4) frame(W);

        chk("write_during_active", lb_viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
